// File: rtl/uart_tx_scheduler_pkg.sv
// Shared UART transmit types, framing constants, config clamp limits and latch-time helpers.
// Pure definitions: no latency or backpressure of its own.
package UartGlobalPkg;

    typedef enum logic [2:0] {
        RESET,
        IDLE,
        STARTBIT,
        DATABITTRANSFER,
        PARITYBIT,
        STOPBIT
    } UartTransmitterStateEnum;

    localparam int   DATA_WIDTH     = 8;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   MIN_DATA_BITS  = 5;
    localparam int   MAX_DATA_BITS  = 8;
    localparam int   MIN_BIT_CYCLES = 2;

    // Returns (data bits - 1) so it fits the 3-bit data-bit index.
    function automatic logic [2:0] clampDataBitsM1(input logic [3:0] n);
        if (n < 4'(MIN_DATA_BITS)) begin
            return 3'(MIN_DATA_BITS - 1);
        end else if (n > 4'(MAX_DATA_BITS)) begin
            return 3'(MAX_DATA_BITS - 1);
        end else begin
            return 3'(n - 4'd1);
        end
    endfunction

    function automatic logic [15:0] clampBitCycles(input logic [15:0] c);
        return (c < 16'(MIN_BIT_CYCLES)) ? 16'(MIN_BIT_CYCLES) : c;
    endfunction

    function automatic logic maskedParity(input logic [MAX_DATA_BITS-1:0] d,
                                          input logic [2:0] last_idx);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i <= int'(last_idx)) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin winner select (combinational) with a registered pointer that moves past each winner.
// Winner valid in the same cycle as req; pointer advances only when advance_i accepts a winner.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    // Scan from the farthest offset back to the pointer so the nearest requester is written last.
    always_comb begin
        int idx;
        idx       = 0;
        winner_o  = '0;
        any_req_o = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_i[idx]) begin
                winner_o  = IDX_W'(idx);
                any_req_o = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = (int'(winner_o) == NUM_REQ - 1) ? '0 : winner_o + IDX_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (advance_i && any_req_o) begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART Tx: grant at T, start bit at T+1; requesters hold req until grant (no queueing).
// Optional UART_TX_ERR_INJECTION_EN adds parity-flip and first-stop-bit-low injection inputs.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = UartGlobalPkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            grant,
    input  logic [15:0]                   cfgBitCycles,
    input  logic [3:0]                    cfgDataBits,
    input  logic                          cfgParityEnable,
    input  logic                          cfgParityType,
    input  logic [1:0]                    cfgStopBits,
`ifdef UART_TX_ERR_INJECTION_EN
    input  logic                          cfgParityErrorInjection,
    input  logic                          cfgFramingErrorInjection,
`endif
    output logic                          txLine,
    output logic                          busy,
    output logic                          frameDone,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    import UartGlobalPkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    UartTransmitterStateEnum state_q;

    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic                  advance;
    logic [DATA_WIDTH-1:0] data_sel;
    logic [NUM_REQ-1:0]    grant_d;
    logic [2:0]            data_bits_m1_d;
    logic                  par_bit_d;
    logic                  par_inj_d;
    logic                  fram_inj_d;
    logic                  bit_end;

    logic [NUM_REQ-1:0]    grant_q;
    logic [IDX_W-1:0]      owner_q;
    logic                  tx_line_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [15:0]           bit_cnt_q;
    logic [2:0]            bit_idx_q;
    logic                  stop_idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [2:0]            data_bits_m1_q;
    logic [15:0]           bit_cycles_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  two_stop_q;
    logic                  fram_err_q;

`ifdef UART_TX_ERR_INJECTION_EN
    assign par_inj_d  = cfgParityErrorInjection;
    assign fram_inj_d = cfgFramingErrorInjection;
`else
    assign par_inj_d  = 1'b0;
    assign fram_inj_d = 1'b0;
`endif

    assign advance = (state_q == IDLE);

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (req),
        .advance_i (advance),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign data_sel       = reqData[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_d        = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign data_bits_m1_d = clampDataBitsM1(cfgDataBits);
    // Final on-wire parity value is resolved at grant so the PARITYBIT state just replays it.
    assign par_bit_d      = maskedParity(data_sel[MAX_DATA_BITS-1:0], data_bits_m1_d)
                            ^ cfgParityType ^ par_inj_d;
    assign bit_end        = (bit_cnt_q == bit_cycles_q - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RESET;
            grant_q        <= '0;
            owner_q        <= '0;
            tx_line_q      <= STOP_BIT;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            bit_cnt_q      <= '0;
            bit_idx_q      <= '0;
            stop_idx_q     <= 1'b0;
            shift_q        <= '0;
            data_bits_m1_q <= '0;
            bit_cycles_q   <= 16'(MIN_BIT_CYCLES);
            par_en_q       <= 1'b0;
            par_bit_q      <= 1'b0;
            two_stop_q     <= 1'b0;
            fram_err_q     <= 1'b0;
        end else begin
            grant_q      <= '0;
            frame_done_q <= 1'b0;
            case (state_q)
                RESET: begin
                    state_q <= IDLE;
                end
                IDLE: begin
                    tx_line_q <= STOP_BIT;
                    busy_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    if (any_req) begin
                        grant_q        <= grant_d;
                        owner_q        <= winner;
                        shift_q        <= data_sel;
                        data_bits_m1_q <= data_bits_m1_d;
                        bit_cycles_q   <= clampBitCycles(cfgBitCycles);
                        par_en_q       <= cfgParityEnable;
                        par_bit_q      <= par_bit_d;
                        two_stop_q     <= (cfgStopBits >= 2'd2);
                        fram_err_q     <= fram_inj_d;
                        state_q        <= STARTBIT;
                    end
                end
                STARTBIT: begin
                    tx_line_q <= START_BIT;
                    busy_q    <= 1'b1;
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATABITTRANSFER;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                DATABITTRANSFER: begin
                    tx_line_q <= shift_q[0];
                    busy_q    <= 1'b1;
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        shift_q   <= shift_q >> 1;
                        if (bit_idx_q == data_bits_m1_q) begin
                            bit_idx_q  <= '0;
                            stop_idx_q <= 1'b0;
                            state_q    <= par_en_q ? PARITYBIT : STOPBIT;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                PARITYBIT: begin
                    tx_line_q <= par_bit_q;
                    busy_q    <= 1'b1;
                    if (bit_end) begin
                        bit_cnt_q  <= '0;
                        stop_idx_q <= 1'b0;
                        state_q    <= STOPBIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                STOPBIT: begin
                    tx_line_q <= (fram_err_q && !stop_idx_q) ? START_BIT : STOP_BIT;
                    busy_q    <= 1'b1;
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (stop_idx_q == two_stop_q) begin
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign txLine    = tx_line_q;
    assign busy      = busy_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, 8E1, contention, 7O2, clamping, mid-frame reset, injection.
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] reqData;
    logic [1:0]  grant;
    logic [15:0] cfgBitCycles;
    logic [3:0]  cfgDataBits;
    logic        cfgParityEnable;
    logic        cfgParityType;
    logic [1:0]  cfgStopBits;
`ifdef UART_TX_ERR_INJECTION_EN
    logic        cfgParityErrorInjection;
    logic        cfgFramingErrorInjection;
`endif
    logic        txLine;
    logic        busy;
    logic        frameDone;
    logic [0:0]  owner;

    int vectors     = 0;
    int miscompares = 0;

    logic tx_cap   [64];
    logic fd_cap   [64];
    logic busy_cap [64];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(2), .DATA_WIDTH(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req                      (req),
        .reqData                  (reqData),
        .grant                    (grant),
        .cfgBitCycles             (cfgBitCycles),
        .cfgDataBits              (cfgDataBits),
        .cfgParityEnable          (cfgParityEnable),
        .cfgParityType            (cfgParityType),
        .cfgStopBits              (cfgStopBits),
`ifdef UART_TX_ERR_INJECTION_EN
        .cfgParityErrorInjection  (cfgParityErrorInjection),
        .cfgFramingErrorInjection (cfgFramingErrorInjection),
`endif
        .txLine                   (txLine),
        .busy                     (busy),
        .frameDone                (frameDone),
        .owner                    (owner)
    );

    task automatic set_cfg(input int bc, input int db, input bit pe, input bit pt, input int sb);
        cfgBitCycles    = 16'(bc);
        cfgDataBits     = 4'(db);
        cfgParityEnable = pe;
        cfgParityType   = pt;
        cfgStopBits     = 2'(sb);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_grant(input int bound, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < bound) begin
            @(negedge clk);
            waited++;
            if (grant != 2'b00) seen = 1'b1;
        end
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tx_cap[k]   = txLine;
            fd_cap[k]   = frameDone;
            busy_cap[k] = busy;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({txLine, busy, frameDone, grant, owner} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_values: got %b want 100000", {txLine, busy, frameDone, grant, owner});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({txLine, busy, grant} !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_no_req: got %b want 1000", {txLine, busy, grant});
        end
    endtask

    task automatic test_basic_8e1;
        int w;
        bit seen;
        int fd_n;
        int exp_bits[$];
        exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        do_reset();
        set_cfg(4, 8, 1'b1, 1'b0, 1);
        reqData = 16'h00A5;
        req     = 2'b01;
        wait_grant(20, w, seen);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL basic_grant_timeout: got none want grant");
        end
        vectors++;
        if ({grant, owner, txLine, busy} !== 5'b01010) begin
            miscompares++;
            $display("FAIL basic_grant_cycle: got %b want 01010", {grant, owner, txLine, busy});
        end
        req = 2'b00;
        capture(44);
        fd_n = 0;
        for (int k = 0; k < 44; k++) begin
            vectors++;
            if (tx_cap[k] !== 1'(exp_bits[k/4])) begin
                miscompares++;
                $display("FAIL basic_tx[%0d]: got %b want %0d", k, tx_cap[k], exp_bits[k/4]);
            end
            if (fd_cap[k] === 1'b1) fd_n++;
        end
        vectors++;
        if (fd_n !== 1 || fd_cap[43] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_frame_done: got count %0d last %b want 1 1", fd_n, fd_cap[43]);
        end
        vectors++;
        if (busy_cap[0] !== 1'b1 || busy_cap[42] !== 1'b1 || busy_cap[43] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got %b%b%b want 110", busy_cap[0], busy_cap[42], busy_cap[43]);
        end
        @(negedge clk);
        vectors++;
        if ({txLine, busy, frameDone} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_after: got %b want 100", {txLine, busy, frameDone});
        end
    endtask

    task automatic test_contention;
        int w;
        bit seen;
        int eo;
        int e0[$];
        int e1[$];
        e0 = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        e1 = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
        do_reset();
        set_cfg(2, 8, 1'b0, 1'b0, 1);
        reqData = 16'h2211;
        req     = 2'b11;
        for (int f = 0; f < 4; f++) begin
            eo = f % 2;
            wait_grant(20, w, seen);
            vectors++;
            if (!seen || grant !== (2'b01 << eo) || owner !== 1'(eo)) begin
                miscompares++;
                $display("FAIL cont_grant[%0d]: got seen %b grant %b owner %b want grant %b owner %0d",
                         f, seen, grant, owner, 2'b01 << eo, eo);
            end
            if (f > 0) begin
                vectors++;
                if (w !== 1 || txLine !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cont_gap[%0d]: got %0d cycles tx %b want 1 cycles tx 1", f, w, txLine);
                end
            end
            if (f == 3) req = 2'b00;
            capture(20);
            for (int k = 0; k < 20; k++) begin
                vectors++;
                if (tx_cap[k] !== 1'(eo ? e1[k/2] : e0[k/2])) begin
                    miscompares++;
                    $display("FAIL cont_tx[%0d][%0d]: got %b want %0d", f, k, tx_cap[k],
                             eo ? e1[k/2] : e0[k/2]);
                end
            end
            vectors++;
            if (fd_cap[19] !== 1'b1 || fd_cap[18] !== 1'b0 || owner !== 1'(eo)) begin
                miscompares++;
                $display("FAIL cont_done[%0d]: got fd %b%b owner %b want 01 owner %0d",
                         f, fd_cap[18], fd_cap[19], owner, eo);
            end
        end
    endtask

    task automatic test_7o2;
        int w;
        bit seen;
        int fd_n;
        int exp_bits[$];
        exp_bits = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        do_reset();
        set_cfg(3, 7, 1'b1, 1'b1, 2);
        reqData = 16'h00FF;
        req     = 2'b01;
        wait_grant(20, w, seen);
        vectors++;
        if (!seen || grant !== 2'b01) begin
            miscompares++;
            $display("FAIL o2_grant: got %b want 01", grant);
        end
        req = 2'b00;
        capture(34);
        fd_n = 0;
        for (int k = 0; k < 33; k++) begin
            vectors++;
            if (tx_cap[k] !== 1'(exp_bits[k/3])) begin
                miscompares++;
                $display("FAIL o2_tx[%0d]: got %b want %0d", k, tx_cap[k], exp_bits[k/3]);
            end
            if (fd_cap[k] === 1'b1) fd_n++;
        end
        vectors++;
        if (fd_n !== 1 || fd_cap[32] !== 1'b1 || busy_cap[33] !== 1'b0 || tx_cap[33] !== 1'b1) begin
            miscompares++;
            $display("FAIL o2_end: got count %0d last %b busy %b tx %b want 1 1 0 1",
                     fd_n, fd_cap[32], busy_cap[33], tx_cap[33]);
        end
    endtask

    task automatic test_clamp;
        int w;
        bit seen;
        int exp_bits[$];
        exp_bits = '{0, 1, 0, 1, 1, 0, 1};
        do_reset();
        set_cfg(1, 3, 1'b0, 1'b0, 0);
        reqData = 16'h00ED;
        req     = 2'b01;
        wait_grant(20, w, seen);
        vectors++;
        if (!seen || grant !== 2'b01) begin
            miscompares++;
            $display("FAIL clamp_grant: got %b want 01", grant);
        end
        req = 2'b00;
        capture(16);
        for (int k = 0; k < 14; k++) begin
            vectors++;
            if (tx_cap[k] !== 1'(exp_bits[k/2])) begin
                miscompares++;
                $display("FAIL clamp_tx[%0d]: got %b want %0d", k, tx_cap[k], exp_bits[k/2]);
            end
        end
        vectors++;
        if (fd_cap[13] !== 1'b1 || fd_cap[12] !== 1'b0 || busy_cap[14] !== 1'b0 || tx_cap[15] !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_end: got fd %b%b busy %b tx %b want 10 0 1",
                     fd_cap[13], fd_cap[12], busy_cap[14], tx_cap[15]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int w;
        bit seen;
        bit fd_seen;
        do_reset();
        set_cfg(4, 8, 1'b0, 1'b0, 1);
        reqData = 16'h0000;
        req     = 2'b01;
        wait_grant(20, w, seen);
        req = 2'b00;
        repeat (10) @(negedge clk);
        vectors++;
        if ({txLine, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_pre: got %b want 01", {txLine, busy});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({txLine, busy, frameDone} !== 3'b100) begin
            miscompares++;
            $display("FAIL mid_async: got %b want 100", {txLine, busy, frameDone});
        end
        fd_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (frameDone !== 1'b0 || txLine !== 1'b1) fd_seen = 1'b1;
        end
        req     = 2'b11;
        reqData = 16'h2211;
        reset   = 1'b1;
        seen    = 1'b0;
        w       = 0;
        while (!seen && w < 20) begin
            @(negedge clk);
            w++;
            if (frameDone !== 1'b0) fd_seen = 1'b1;
            if (grant != 2'b00) seen = 1'b1;
        end
        vectors++;
        if (fd_seen) begin
            miscompares++;
            $display("FAIL mid_no_done: got stray frameDone or tx low want none");
        end
        vectors++;
        if (!seen || grant !== 2'b01 || owner !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_first_grant: got %b owner %b want 01 owner 0", grant, owner);
        end
        req = 2'b00;
        capture(40);
        vectors++;
        if (fd_cap[39] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_next_frame: got %b want 1", fd_cap[39]);
        end
    endtask

`ifdef UART_TX_ERR_INJECTION_EN
    task automatic test_err_injection;
        int w;
        bit seen;
        int ef[$];
        int ep[$];
        ef = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
        ep = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        do_reset();
        set_cfg(2, 8, 1'b1, 1'b0, 2);
        cfgFramingErrorInjection = 1'b1;
        cfgParityErrorInjection  = 1'b0;
        reqData = 16'h00A5;
        req     = 2'b01;
        wait_grant(20, w, seen);
        req = 2'b00;
        cfgFramingErrorInjection = 1'b0;
        capture(24);
        for (int k = 0; k < 24; k++) begin
            vectors++;
            if (tx_cap[k] !== 1'(ef[k/2])) begin
                miscompares++;
                $display("FAIL inj_framing_tx[%0d]: got %b want %0d", k, tx_cap[k], ef[k/2]);
            end
        end
        set_cfg(2, 8, 1'b1, 1'b0, 1);
        cfgParityErrorInjection = 1'b1;
        req = 2'b01;
        wait_grant(20, w, seen);
        req = 2'b00;
        cfgParityErrorInjection = 1'b0;
        capture(22);
        for (int k = 0; k < 22; k++) begin
            vectors++;
            if (tx_cap[k] !== 1'(ep[k/2])) begin
                miscompares++;
                $display("FAIL inj_parity_tx[%0d]: got %b want %0d", k, tx_cap[k], ep[k/2]);
            end
        end
    endtask
`endif

    initial begin
        reset   = 1'b0;
        req     = 2'b00;
        reqData = 16'h0000;
        set_cfg(4, 8, 1'b0, 1'b0, 1);
`ifdef UART_TX_ERR_INJECTION_EN
        cfgParityErrorInjection  = 1'b0;
        cfgFramingErrorInjection = 1'b0;
`endif
        test_reset();
        test_basic_8e1();
        test_contention();
        test_7o2();
        test_clamp();
        test_reset_mid_frame();
`ifdef UART_TX_ERR_INJECTION_EN
        test_err_injection();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler and frame sequencer that shares one UART transmit line between `NUM_REQ` byte requesters. It arbitrates among pending requests, latches the winner's byte and the current line configuration, and sequences start, data, parity and stop bits onto `txLine` at a programmed bit period. It sits between the transmit-side agents and the serial pin, and is the only driver of the Tx line.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (2..8)
- `DATA_WIDTH`, 8, maximum data bits per frame

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  requester i has a byte pending
- `reqData`  in  NUM_REQ*DATA_WIDTH  byte of requester i in slice [i*DATA_WIDTH +: DATA_WIDTH]
- `grant`  out  NUM_REQ  one-cycle pulse: requester i's byte accepted
- `cfgBitCycles`  in  16  clock cycles per bit
- `cfgDataBits`  in  4  data bits per frame, 5..8
- `cfgParityEnable`  in  1  parity bit inserted
- `cfgParityType`  in  1  0 = even, 1 = odd
- `cfgStopBits`  in  2  1 or 2 stop bits
- `txLine`  out  1  serial output; idles high
- `busy`  out  1  frame in progress
- `frameDone`  out  1  one-cycle pulse at the end of a frame
- `owner`  out  $clog2(NUM_REQ)  index of the requester owning the current frame

## Operation
- FSM states (`UartTransmitterStateEnum`): RESET, IDLE, STARTBIT, DATABITTRANSFER, PARITYBIT, STOPBIT.
- RESET is held while `reset` is low. After release, the FSM enters IDLE on the next edge.
- IDLE, with any `req` bit high:
  - The arbiter picks the winner round-robin, starting from pointer `rrPtr`.
  - `grant[winner]` pulses and the winner's `reqData` is latched, together with all `cfg*` inputs.
  - `owner` is set to the winner, `rrPtr` is set to (winner+1) mod NUM_REQ, and the FSM goes to STARTBIT.
- STARTBIT: `txLine` = 0 for one bit time.
- DATABITTRANSFER: LSB first, exactly `cfgDataBits` bits. Bits above that count are ignored.
- PARITYBIT: present only if `cfgParityEnable`.
  - Parity value = XOR of the transmitted data bits.
  - Even parity: the bit is sent as that XOR. Odd parity: the bit is sent inverted.
- STOPBIT: `txLine` = 1 for `cfgStopBits` bit times. In the last cycle, `frameDone` pulses, `busy` drops and the FSM returns to IDLE.
- Requester contract:
  - Hold `req` and `reqData` stable until `grant`.
  - Dropping `req` before `grant` withdraws the request.
  - Data is sampled in the grant cycle.
- Out-of-range config is clamped when latched:
  - `cfgDataBits` below 5 becomes 5; above 8 becomes 8.
  - `cfgStopBits` of 0 becomes 1; 3 becomes 2.
  - `cfgBitCycles` below 2 becomes 2.
- Config changes during a frame take effect at the next grant.
- A bit counter (16-bit) and a data-bit index (3-bit) reset at each bit or frame boundary. There is no wrap across frames.

## Timing
- Reset values: `txLine`=1, `busy`=0, `frameDone`=0, `grant`=0, `owner`=0, `rrPtr`=0. All outputs are registered.
- A reset mid-frame forces `txLine` high asynchronously and aborts the frame. No `frameDone` is issued.
- Grant in cycle T → `txLine` falls and `busy` rises at T+1.
- Each bit lasts exactly `cfgBitCycles` clocks.
- Frame length = `cfgBitCycles`*(1+D+P+S) clocks.
- The FSM spends at least one cycle in IDLE between frames, so there is a 1-clock minimum gap with `txLine` high.
- Requests that are simultaneous or pending during a frame are arbitrated in the first IDLE cycle. At most one `grant` bit is high in any cycle.

## Configuration
- `UART_TX_ERR_INJECTION_EN`: adds input ports `cfgParityErrorInjection` and `cfgFramingErrorInjection`, both latched at grant.
  - Parity injection inverts the parity bit.
  - Framing injection drives the first stop bit low.
- Without the macro, neither port exists and frames are always well-formed.

## Structure
- `UartGlobalPkg` holds:
  - `UartTransmitterStateEnum`
  - `DATA_WIDTH`, `START_BIT`, `STOP_BIT`
  - the clamp limits (min 5 and max 8 data bits; min 2 bit cycles)
- Sub-module `uart_rr_arbiter`: combinational winner select from `req` and `rrPtr`, plus the registered pointer update.

## Test plan
- **Basic 8E1 frame:** `cfgBitCycles`=4, 8 data bits, even parity, 1 stop; `req[0]` with 0xA5.
  - `txLine` over 44 clocks is 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clocks.
  - `frameDone` pulses once.
- **Contention:** `req`=2'b11 held continuously with 0x11 and 0x22.
  - Grants alternate 0,1,0,1.
  - `owner` matches each frame.
  - Gap between frames is exactly 1 clock.
- **7O2 frame:** 7 data bits, odd parity, 2 stops, data 0xFF.
  - Bit 7 is not sent, parity bit is 0, two high stop bits.
  - Frame is 11 bit times.
- **Clamping:** `cfgDataBits`=3, `cfgStopBits`=0, `cfgBitCycles`=1 → frame of 5 data bits, 1 stop bit, 2 clocks per bit.
- **Reset mid-frame:** assert `reset` during DATABITTRANSFER.
  - `txLine`=1 immediately, `busy`=0, no `frameDone`.
  - After release, the first grant goes to requester 0.
- **Error injection (macro on):** set `cfgFramingErrorInjection`=1.
  - First stop bit is 0.
  - Parity injection flips the 0xA5 even parity bit from 0 to 1.
